// File: rtl/vend_controller.sv
// Coin-collect sequencing controller: keeps credit in 25-paise units and runs the
// dispense handshake, then the one-coin-per-ack change or refund handshake.
module vend_controller #(
  parameter int PRICE_UNITS      = 4,
  parameter int MAX_CREDIT_UNITS = 7,
  parameter int TIMEOUT_CYCLES   = 1000,
  parameter int TMR_W            = 10
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic [1:0] coin,
  input  logic       cancel,
  input  logic       dispense_ack,
  input  logic       change_ack,
  output logic       vend_req,
  output logic       change_req,
  output logic [2:0] credit,
  output logic       coin_reject,
  output logic       done,
  output logic       busy
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_COLLECT = 2'd1;
  localparam logic [1:0] ST_VEND    = 2'd2;
  localparam logic [1:0] ST_CHANGE  = 2'd3;

  localparam logic [3:0]       PRICE_W  = 4'(PRICE_UNITS);
  localparam logic [2:0]       PRICE_C  = 3'(PRICE_UNITS);
  localparam logic [3:0]       MAX_W    = 4'(MAX_CREDIT_UNITS);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

  logic [1:0]       state;
  logic [TMR_W-1:0] timer;
  logic [2:0]       coin_units;
  logic             coin_valid;
  logic [3:0]       sum;
  logic             overflow;

  // NOTE: every variable written in always_comb gets a default first, otherwise a latch is inferred.
  always_comb begin
    coin_units = 3'd0;
    case (coin)
      2'b00:   coin_units = 3'd1;
      2'b01:   coin_units = 3'd2;
      2'b10:   coin_units = 3'd4;
      default: coin_units = 3'd0;
    endcase
  end

  assign coin_valid = (coin != 2'b11);
  // One bit wider than credit so the limit test cannot wrap.
  assign sum        = {1'b0, credit} + {1'b0, coin_units};
  assign overflow   = (sum > MAX_W);

  // NOTE: state registers use non-blocking assignments so every branch sees pre-edge values.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      // NOTE: all control state is reset; there is no storage array here that could be left unreset.
      state       <= ST_IDLE;
      credit      <= 3'd0;
      timer       <= '0;
      coin_reject <= 1'b0;
      done        <= 1'b0;
    end else begin
      coin_reject <= 1'b0;
      done        <= 1'b0;
      timer       <= '0;
      case (state)
        ST_IDLE, ST_COLLECT: begin
          if (cancel && credit != 3'd0) begin
            state       <= ST_CHANGE;
            coin_reject <= coin_valid;
          end else if (coin_valid && !overflow) begin
            credit <= sum[2:0];
            state  <= (sum >= PRICE_W) ? ST_VEND : ST_COLLECT;
          end else begin
            coin_reject <= coin_valid;
            if (state == ST_COLLECT) begin
              if (timer == TMR_LAST) state <= ST_CHANGE;
              else                   timer <= timer + TMR_W'(1);
            end
          end
        end
        ST_VEND: begin
          coin_reject <= coin_valid;
          if (dispense_ack) begin
            credit <= credit - PRICE_C;
            done   <= 1'b1;
            state  <= (credit > PRICE_C) ? ST_CHANGE : ST_IDLE;
          end
        end
        ST_CHANGE: begin
          coin_reject <= coin_valid;
          if (change_ack && credit != 3'd0) begin
            credit <= credit - 3'd1;
            if (credit == 3'd1) state <= ST_IDLE;
          end else if (credit == 3'd0) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign vend_req   = (state == ST_VEND);
  assign change_req = (state == ST_CHANGE);
  assign busy       = vend_req | change_req;

endmodule

// File: tb/tb_vend_controller.sv
// Bench for vend_controller: table vectors, directed corner sequences and random
// traffic on two instances (price 4 and price 6) checked against a behavioural model.
module tb_vend_controller;

  localparam int MAX_UNITS = 7;
  localparam int TIMEOUT   = 16;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic [1:0] coin = 2'b11;
  logic       cancel = 1'b0, dispense_ack = 1'b0, change_ack = 1'b0;

  logic       vend_a, chg_a, rej_a, done_a, busy_a;
  logic [2:0] credit_a;
  logic       vend_b, chg_b, rej_b, done_b, busy_b;
  logic [2:0] credit_b;

  vend_controller #(.PRICE_UNITS(4), .MAX_CREDIT_UNITS(MAX_UNITS), .TIMEOUT_CYCLES(TIMEOUT), .TMR_W(4)) dut_a (
    .clock(clock), .reset_n(reset_n), .coin(coin), .cancel(cancel),
    .dispense_ack(dispense_ack), .change_ack(change_ack),
    .vend_req(vend_a), .change_req(chg_a), .credit(credit_a),
    .coin_reject(rej_a), .done(done_a), .busy(busy_a));

  vend_controller #(.PRICE_UNITS(6), .MAX_CREDIT_UNITS(MAX_UNITS), .TIMEOUT_CYCLES(TIMEOUT), .TMR_W(5)) dut_b (
    .clock(clock), .reset_n(reset_n), .coin(coin), .cancel(cancel),
    .dispense_ack(dispense_ack), .change_ack(change_ack),
    .vend_req(vend_b), .change_req(chg_b), .credit(credit_b),
    .coin_reject(rej_b), .done(done_b), .busy(busy_b));

  always #5 clock = ~clock;

  typedef enum {M_IDLE, M_COLLECT, M_VEND, M_CHANGE} mode_e;
  typedef struct {
    mode_e mode;
    int    credit;
    int    idle;
    int    price;
    bit    rej;
    bit    done;
  } model_t;

  typedef struct {
    logic [1:0] coin;
    logic       cancel, dack, cack;
    int         credit;
    logic       vend, chg, rej, done;
  } vec_t;

  model_t ma, mb;
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  function automatic model_t model_reset(input int price);
    model_t m;
    m.mode = M_IDLE; m.credit = 0; m.idle = 0; m.price = price; m.rej = 0; m.done = 0;
    return m;
  endfunction

  // Applies the rules for one clock edge to the abstract machine.
  function automatic model_t model_step(input model_t m, input logic [1:0] c,
                                        input logic cn, input logic da, input logic ca);
    int v;
    v = (c == 2'b00) ? 1 : (c == 2'b01) ? 2 : (c == 2'b10) ? 4 : 0;
    m.rej = 0;
    m.done = 0;
    case (m.mode)
      M_IDLE, M_COLLECT: begin
        if (cn && m.credit > 0) begin
          m.rej = (v > 0); m.mode = M_CHANGE; m.idle = 0;
        end else if (v > 0 && m.credit + v <= MAX_UNITS) begin
          m.credit += v; m.idle = 0;
          m.mode = (m.credit >= m.price) ? M_VEND : M_COLLECT;
        end else begin
          m.rej = (v > 0);
          if (m.mode == M_COLLECT) begin
            m.idle++;
            if (m.idle == TIMEOUT) begin m.mode = M_CHANGE; m.idle = 0; end
          end
        end
      end
      M_VEND: begin
        m.rej = (v > 0);
        if (da) begin
          m.credit -= m.price; m.done = 1;
          m.mode = (m.credit > 0) ? M_CHANGE : M_IDLE;
        end
      end
      default: begin
        m.rej = (v > 0);
        if (ca && m.credit > 0) begin
          m.credit--;
          if (m.credit == 0) m.mode = M_IDLE;
        end
      end
    endcase
    return m;
  endfunction

  task automatic compare(input string tag, input model_t m, input logic v, input logic ch,
                         input logic [2:0] cr, input logic rj, input logic dn, input logic bz);
    check({tag, ".vend_req"},    v,  m.mode == M_VEND);
    check({tag, ".change_req"},  ch, m.mode == M_CHANGE);
    check({tag, ".credit"},      cr, m.credit);
    check({tag, ".coin_reject"}, rj, m.rej);
    check({tag, ".done"},        dn, m.done);
    check({tag, ".busy"},        bz, m.mode == M_VEND || m.mode == M_CHANGE);
  endtask

  task automatic compare_all();
    compare("a", ma, vend_a, chg_a, credit_a, rej_a, done_a, busy_a);
    compare("b", mb, vend_b, chg_b, credit_b, rej_b, done_b, busy_b);
  endtask

  task automatic cycle(input logic [1:0] c, input logic cn, input logic da, input logic ca);
    coin = c; cancel = cn; dispense_ack = da; change_ack = ca;
    @(posedge clock);
    ma = model_step(ma, c, cn, da, ca);
    mb = model_step(mb, c, cn, da, ca);
    #1;
    compare_all();
  endtask

  task automatic do_reset();
    coin = 2'b11; cancel = 0; dispense_ack = 0; change_ack = 0;
    @(negedge clock);
    reset_n = 0;
    ma = model_reset(4);
    mb = model_reset(6);
    #1;
    compare_all();
    @(negedge clock);
    reset_n = 1;
  endtask

  // Counts idle cycles until dut_a raises change_req; returns 0 if the bound expires.
  task automatic cycles_to_change(output int n);
    n = 0;
    for (int i = 1; i <= 40; i++) begin
      cycle(2'b11, 0, 0, 0);
      if (chg_a) begin n = i; break; end
    end
  endtask

  task automatic drain_change(output int acks);
    acks = 0;
    for (int i = 0; i < 10; i++) begin
      if (!chg_a) break;
      cycle(2'b11, 0, 0, 1);
      acks++;
    end
  endtask

  vec_t vecs[$];

  initial begin
    int n, acks;
    logic [1:0] c;

    // exact pay, then overpay with change (dut_a, price 4)
    vecs.push_back('{2'b00, 0, 0, 0, 1, 0, 0, 0, 0});
    vecs.push_back('{2'b00, 0, 0, 0, 2, 0, 0, 0, 0});
    vecs.push_back('{2'b00, 0, 0, 0, 3, 0, 0, 0, 0});
    vecs.push_back('{2'b00, 0, 0, 0, 4, 1, 0, 0, 0});
    vecs.push_back('{2'b11, 0, 0, 0, 4, 1, 0, 0, 0});
    vecs.push_back('{2'b11, 0, 0, 0, 4, 1, 0, 0, 0});
    vecs.push_back('{2'b11, 0, 1, 0, 0, 0, 0, 0, 1});
    vecs.push_back('{2'b11, 0, 0, 0, 0, 0, 0, 0, 0});
    vecs.push_back('{2'b01, 0, 0, 0, 2, 0, 0, 0, 0});
    vecs.push_back('{2'b10, 0, 0, 0, 6, 1, 0, 0, 0});
    vecs.push_back('{2'b00, 0, 0, 0, 6, 1, 0, 1, 0});
    vecs.push_back('{2'b11, 0, 1, 0, 2, 0, 1, 0, 1});
    vecs.push_back('{2'b11, 0, 0, 1, 1, 0, 1, 0, 0});
    vecs.push_back('{2'b11, 0, 0, 1, 0, 0, 0, 0, 0});
    vecs.push_back('{2'b11, 0, 0, 0, 0, 0, 0, 0, 0});

    do_reset();
    for (int i = 0; i < vecs.size(); i++) begin
      cycle(vecs[i].coin, vecs[i].cancel, vecs[i].dack, vecs[i].cack);
      check($sformatf("vec%0d.credit", i),      credit_a, vecs[i].credit);
      check($sformatf("vec%0d.vend_req", i),    vend_a,   vecs[i].vend);
      check($sformatf("vec%0d.change_req", i),  chg_a,    vecs[i].chg);
      check($sformatf("vec%0d.coin_reject", i), rej_a,    vecs[i].rej);
      check($sformatf("vec%0d.done", i),        done_a,   vecs[i].done);
    end

    // asynchronous reset from VEND with credit 6
    do_reset();
    cycle(2'b01, 0, 0, 0);
    cycle(2'b10, 0, 0, 0);
    check("arst.pre_credit", credit_a, 6);
    check("arst.pre_vend", vend_a, 1);
    #2 reset_n = 0;
    #1;
    check("arst.vend_req", vend_a, 0);
    check("arst.credit", credit_a, 0);
    check("arst.busy", busy_a, 0);
    ma = model_reset(4);
    mb = model_reset(6);
    @(posedge clock);
    @(negedge clock);
    reset_n = 1;
    cycle(2'b11, 0, 1, 0);
    check("arst.idle_vend", vend_a, 0);
    check("arst.idle_done", done_a, 0);

    // cancel colliding with a coin while credit is 3
    cycle(2'b01, 0, 0, 0);
    cycle(2'b00, 0, 0, 0);
    check("cancel.credit3", credit_a, 3);
    cycle(2'b01, 1, 0, 0);
    check("cancel.reject", rej_a, 1);
    check("cancel.change_req", chg_a, 1);
    check("cancel.credit", credit_a, 3);
    drain_change(acks);
    check("cancel.acks", acks, 3);
    check("cancel.final_credit", credit_a, 0);

    // overflow on dut_b (price 6)
    do_reset();
    cycle(2'b10, 0, 0, 0);
    check("ovf.first", credit_b, 4);
    cycle(2'b10, 0, 0, 0);
    check("ovf.reject", rej_b, 1);
    check("ovf.credit_kept", credit_b, 4);
    cycle(2'b01, 0, 0, 0);
    check("ovf.credit6", credit_b, 6);
    check("ovf.vend", vend_b, 1);
    cycle(2'b11, 0, 1, 0);
    check("ovf.done", done_b, 1);

    // idle timeout, then a restart of the count by a coin at cycle 10
    do_reset();
    cycle(2'b00, 0, 0, 0);
    check("tmo.credit1", credit_a, 1);
    cycles_to_change(n);
    check("tmo.cycles", n, 16);
    drain_change(acks);
    check("tmo.refund_acks", acks, 1);
    cycle(2'b00, 0, 0, 0);
    repeat (9) cycle(2'b11, 0, 0, 0);
    cycle(2'b00, 0, 0, 0);
    check("tmo.restart_credit", credit_a, 2);
    cycles_to_change(n);
    check("tmo.restart_cycles", n, 16);
    drain_change(acks);
    check("tmo.restart_acks", acks, 2);

    // random traffic: busy coin flow, then sparse coins so timeouts occur
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      c = ($urandom_range(3) == 0) ? 2'b11 : 2'($urandom_range(2));
      cycle(c, $urandom_range(15) == 0, $urandom_range(2) == 0, $urandom_range(2) == 0);
    end
    for (int i = 0; i < 1500; i++) begin
      c = ($urandom_range(29) == 0) ? 2'($urandom_range(2)) : 2'b11;
      cycle(c, $urandom_range(63) == 0, $urandom_range(3) == 0, $urandom_range(3) == 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/vend_controller.md
Name: vend_controller

Overview:
- Sequencing controller for the coin-collect datapath.
- Accepts coin events on the standard 2-bit coin code and keeps a credit count in 25-paise units.
- Runs the product-dispense handshake, then returns change or refunds one 25-paise unit per change-unit handshake.
- Sits between the coin acceptor and the dispenser/change mechanics. The display block reads its credit output.

Parameters:
PRICE_UNITS, 4, product price in 25-paise units (4 = 1 rupee); legal 1..MAX_CREDIT_UNITS
MAX_CREDIT_UNITS, 7, maximum credit held (7 = 175 paise); legal PRICE_UNITS..7
TIMEOUT_CYCLES, 1000, idle cycles in COLLECT before automatic refund; legal >= 2
TMR_W, 10, timer width; must satisfy 2^TMR_W >= TIMEOUT_CYCLES

Ports:
clock  input  1  system clock, rising edge
reset_n  input  1  asynchronous active-low reset
coin  input  2  00=25p (1 unit), 01=50p (2), 10=100p (4), 11=no coin; sampled every edge
cancel  input  1  user refund request, level sampled
dispense_ack  input  1  dispenser has released product
change_ack  input  1  change unit has paid out one 25-paise coin
vend_req  output  1  dispense request, held until acked
change_req  output  1  pay-out request, one unit per ack
credit  output  3  current credit in 25-paise units
coin_reject  output  1  1-cycle pulse: sampled coin returned to user
done  output  1  1-cycle pulse: vend completed
busy  output  1  high in VEND or CHANGE

Behaviour:
- Reset:
  - reset_n low clears state to IDLE, credit=0, timer=0.
  - All outputs are 0 immediately, without waiting for a clock edge.
  - Any in-flight handshake is abandoned. Release is synchronous to clock.
- All outputs are registered or decoded from registered state only.
- vend_req=(state==VEND), change_req=(state==CHANGE), busy=vend_req|change_req.
- Valid coin: coin!=11. Value v = 1, 2 or 4 units.
- IDLE / COLLECT, on each edge, evaluated in this priority order:
  1. cancel=1 and credit>0: go to CHANGE (full refund). A valid coin in the same cycle gets coin_reject.
  2. cancel=1 and credit==0: cancel is ignored. Coin handling in rule 3 still applies.
  3. Valid coin and credit+v > MAX_CREDIT_UNITS: pulse coin_reject; credit is unchanged.
  4. Valid coin, accepted: credit <= credit+v and timer <= 0.
     - If credit+v >= PRICE_UNITS, go to VEND on this same edge, so vend_req is high in the next cycle.
     - Otherwise go to COLLECT.
  5. In COLLECT with no accepted coin: timer increments. When timer==TIMEOUT_CYCLES-1, go to CHANGE (full refund) and clear the timer.
- The adder is 4 bits wide, so the overflow comparison cannot wrap.
- VEND:
  - vend_req is held high.
  - A valid coin pulses coin_reject. cancel is ignored.
  - On dispense_ack=1: credit <= credit-PRICE_UNITS and done pulses in the next cycle.
  - Next state is CHANGE if the remainder > 0, else IDLE.
  - dispense_ack outside VEND is ignored.
- CHANGE:
  - change_req is held high.
  - A valid coin pulses coin_reject. cancel is ignored.
  - Each edge with change_ack=1: credit <= credit-1.
  - If credit==1 at that ack, go to IDLE, so change_req drops in the same cycle that credit reads 0.
  - change_ack outside CHANGE is ignored.
  - credit never underflows.
- Timer runs only in COLLECT; it is held at 0 in every other state.
- done and coin_reject never assert together with reset_n low. Both may be high in the same cycle otherwise.

Test Plan:
1. Async reset: from VEND with credit=6, drop reset_n mid-cycle -> vend_req, credit, busy are 0 before the next edge; after release, state is IDLE.
2. Exact pay: four 25p coins on consecutive cycles -> credit 1, 2, 3; vend_req high the cycle after the 4th coin; dispense_ack 3 cycles later -> done 1-cycle pulse, credit=0, IDLE, change_req never high.
3. Overpay with change: coins 50p then 100p -> credit 2 then 6, VEND. During VEND a 25p coin -> coin_reject pulse, credit stays 6. dispense_ack -> credit 2, CHANGE. Two change_ack -> credit 1, then 0, change_req low, IDLE.
4. Cancel collision: credit=3 in COLLECT; cancel=1 with coin=01 in the same cycle -> coin_reject, CHANGE, exactly 3 change_ack consumed, credit 0.
5. Overflow (PRICE_UNITS=6): coins 100p, 100p -> second coin coin_reject, credit stays 4. Then 50p -> credit 6, VEND.
6. Timeout (TIMEOUT_CYCLES=16): one 25p coin, then coin=11 -> change_req rises 16 cycles after credit=1. A coin accepted at cycle 10 instead restarts the count.
